// File: rtl/adc_scan_ctrl_if.sv
// Signal bundle between the ADC scan controller, its SPI conversion stage and
// the sample consumer. Names keep the _i/_o sense seen from the controller.
interface adc_scan_ctrl_if;
   logic        start_i;
   logic        cont_i;
   logic [2:0]  nch_i;
   logic [7:0]  gap_i;
   logic        eoc_i;
   logic [11:0] dout_i;
   logic        ready_i;
   logic        strc_o;
   logic [7:0]  cmd_o;
   logic [14:0] data_o;
   logic        valid_o;
   logic        busy_o;
   logic        ovf_o;
   logic        tmo_o;

   // Environment side: drives requests, SPI results and consumer ready.
   modport master (
      output start_i, cont_i, nch_i, gap_i, eoc_i, dout_i, ready_i,
      input  strc_o, cmd_o, data_o, valid_o, busy_o, ovf_o, tmo_o
   );

   // Controller side.
   modport slave (
      input  start_i, cont_i, nch_i, gap_i, eoc_i, dout_i, ready_i,
      output strc_o, cmd_o, data_o, valid_o, busy_o, ovf_o, tmo_o
   );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan sequencer: issues conversions over channels 0..nch,
// waits for end-of-conversion and queues tagged samples in a 4-deep FWFT FIFO.
module adc_scan_ctrl (
   input  logic            clk_i,
   input  logic            rst_i,
   adc_scan_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_EOC,
      S_STORE,
      S_GAP
   } state_t;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam logic [11:0] TMO_LAST   = 12'd4094;  // 4095 cycles in WAIT_EOC

   state_t      state;
   logic [2:0]  ch;
   logic [2:0]  nch_q;
   logic [7:0]  gap_q;
   logic [7:0]  gap_cnt;
   logic [11:0] tmo_cnt;
   logic        eoc_q;
   logic        strc_q;
   logic        ovf_q;
   logic        tmo_q;

   logic [14:0] fifo_mem [FIFO_DEPTH];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  fifo_cnt;

   logic        fifo_full;
   logic        fifo_valid;
   logic        push;
   logic        pop;
   logic        push_ok;
   logic        drop;
   logic        eoc_rise;

   assign fifo_full  = (fifo_cnt == 3'(FIFO_DEPTH));
   assign fifo_valid = (fifo_cnt != 3'd0);
   assign pop        = fifo_valid & bus.ready_i;
   assign push       = (state == S_STORE);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok    = push & (~fifo_full | pop);
   assign drop       = push & fifo_full & ~pop;
   assign eoc_rise   = bus.eoc_i & ~eoc_q;

   // NOTE: the sample array carries no reset; data_o is gated by valid, so
   // stale contents are never visible and the array can map to plain flops/RAM.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= {ch, bus.dout_i};
      end
   end

   // NOTE: reset is synchronous here, so it lives inside the clocked branch.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         fifo_cnt <= fifo_cnt + {2'b00, push_ok} - {2'b00, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= S_IDLE;
         ch      <= '0;
         nch_q   <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         tmo_cnt <= '0;
         eoc_q   <= 1'b0;
         strc_q  <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         eoc_q  <= bus.eoc_i;
         strc_q <= 1'b0;
         if (drop) begin
            ovf_q <= 1'b1;
         end

         unique case (state)
            S_IDLE: begin
               if (bus.start_i) begin
                  nch_q  <= bus.nch_i;
                  gap_q  <= bus.gap_i;
                  ovf_q  <= 1'b0;
                  tmo_q  <= 1'b0;
                  ch     <= '0;
                  strc_q <= 1'b1;
                  state  <= S_START;
               end
            end

            S_START: begin
               tmo_cnt <= '0;
               state   <= S_WAIT_EOC;
            end

            S_WAIT_EOC: begin
               if (eoc_rise) begin
                  state <= S_STORE;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_q <= 1'b1;
                  ch    <= '0;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
               end
            end

            S_STORE: begin
               if ((ch != nch_q) || bus.cont_i) begin
                  ch <= (ch != nch_q) ? ch + 3'd1 : 3'd0;
                  // With no gap requested the next conversion starts at once.
                  if (gap_q == 8'd0) begin
                     strc_q <= 1'b1;
                     state  <= S_START;
                  end else begin
                     gap_cnt <= gap_q - 8'd1;
                     state   <= S_GAP;
                  end
               end else begin
                  ch    <= '0;
                  state <= S_IDLE;
               end
            end

            S_GAP: begin
               if (gap_cnt == 8'd0) begin
                  strc_q <= 1'b1;
                  state  <= S_START;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.strc_o  = strc_q;
   assign bus.cmd_o   = {1'b1, 1'b1, ch, 3'b000};
   assign bus.data_o  = fifo_valid ? fifo_mem[rd_ptr] : 15'd0;
   assign bus.valid_o = fifo_valid;
   assign bus.busy_o  = (state != S_IDLE);
   assign bus.ovf_o   = ovf_q;
   assign bus.tmo_o   = tmo_q;

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clock clk_i; reset rst_i synchronous and active-low.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-low reset
- start_i  in  1  scan request, sampled in IDLE only
- cont_i  in  1  continuous mode; sampled at end of each scan
- nch_i  in  3  last channel index; scan covers 0..nch_i
- gap_i  in  8  idle cycles between conversions
- eoc_i  in  1  end-of-conversion level from the SPI read/write stage
- dout_i  in  12  conversion result from the SPI stage
- ready_i  in  1  consumer accepts head sample
- strc_o  out  1  one-cycle conversion start to the SPI stage
- cmd_o  out  8  ADC command byte to the SPI stage
- data_o  out  15  FIFO head {ch[2:0], sample[11:0]}
- valid_o  out  1  FIFO non-empty
- busy_o  out  1  state != IDLE
- ovf_o  out  1  sticky: a sample was dropped on full FIFO
- tmo_o  out  1  sticky: eoc_i timeout

Function
REQ-003 The FSM SHALL have states IDLE, START, WAIT_EOC, STORE, GAP.
REQ-004 IDLE: start_i=1 SHALL latch nch_i and gap_i into internal registers, clear ovf_o and tmo_o, set channel counter ch=0, and go to START; otherwise stay.
REQ-005 START: strc_o SHALL be 1 for exactly this one cycle, then go to WAIT_EOC.
REQ-006 Latency: start_i sampled high in IDLE at edge n SHALL give strc_o=1 in the cycle after edge n.
REQ-007 cmd_o SHALL equal {1'b1, 1'b1, ch[2:0], 3'b000} (start, single-ended, channel) and SHALL remain stable from START through STORE.
REQ-008 WAIT_EOC: the block SHALL detect a rising edge of eoc_i (registered eoc_i low, current eoc_i high) and go to STORE; a level already high on entry SHALL NOT count.
REQ-009 WAIT_EOC timeout: after 4095 cycles in WAIT_EOC without a rising edge, the block SHALL set tmo_o, reset ch to 0, and go to IDLE without pushing.
REQ-010 STORE: the block SHALL push {ch, dout_i} into the FIFO for one cycle.
- If the FIFO is full and no pop occurs that cycle, the sample SHALL be dropped and ovf_o set.
REQ-011 STORE exit: if ch != latched nch, ch SHALL increment and the FSM SHALL go to GAP.
- If ch == nch and cont_i=1, ch SHALL wrap to 0 and go to GAP.
- If ch == nch and cont_i=0, ch SHALL reset to 0 and go to IDLE.
REQ-012 GAP: a down-counter loaded with latched gap SHALL expire after gap cycles, then go to START; gap=0 SHALL go to START the cycle after STORE.
REQ-013 start_i SHALL be ignored outside IDLE; nch_i/gap_i changes SHALL NOT affect a running scan.
REQ-014 FIFO SHALL be 4 entries deep, first-word fall-through: data_o is the head whenever valid_o=1.
- A pop occurs when valid_o & ready_i.
- data_o SHALL hold its value while valid_o & !ready_i.
REQ-015 Simultaneous push and pop SHALL be accepted when the FIFO is full or empty, with the occupancy count unchanged.
- Empty case: the pushed word SHALL appear at data_o in the next cycle.
REQ-016 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-017 With rst_i=0 at a clock edge, the block SHALL go to IDLE with ch=0 and these output values: strc_o=0, cmd_o=8'hC0, data_o=0, valid_o=0, busy_o=0, ovf_o=0, tmo_o=0.
- The FIFO SHALL be empty and all counters 0.
REQ-018 Reset asserted mid-scan (any state) SHALL abort with no further strc_o or push.
REQ-019 Reset SHALL take priority over all other inputs.

Verification
REQ-020 Single scan: nch_i=2, gap_i=3, cont_i=0, ready_i=1, eoc_i pulsed 20 cycles after each strc_o.
- Expect 3 strc_o pulses with cmd_o=C0, C8, D0.
- Expect data_o ch fields 0, 1, 2 in order, then busy_o=0.
REQ-021 Continuous/stop: nch_i=0, cont_i=1 for 3 conversions, then cont_i=0.
- Expect ch always 0, gap honoured between strc_o pulses, and return to IDLE after the conversion during which cont_i dropped.
REQ-022 Overflow: ready_i=0, nch_i=5.
- Expect the first 4 samples held with data_o = first sample and ovf_o=1 after the 5th.
- With ready_i=1 after the scan: expect exactly 4 pops, ch 0..3.
REQ-023 Full push/pop: FIFO holds 4 entries and ready_i=1 during a STORE.
- Expect the new sample accepted, ovf_o stays 0, occupancy stays 4.
REQ-024 Timeout and reset: eoc_i held 0 after strc_o.
- Expect tmo_o=1 and busy_o=0 after 4095 WAIT_EOC cycles.
- Separately, rst_i=0 during GAP: expect all outputs at REQ-017 values on the next cycle.
REQ-025 eoc_i high on entry to WAIT_EOC: expect no STORE until eoc_i falls and rises again.
